// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : ALU operation encodings, queued command record, legality helper.
// Rev 1.1
// ============================================================================
package alu_pkg;

  localparam int c_DATA_W = 8;
  localparam int c_TAG_W  = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } Op;

  typedef struct packed {
    Op                     op;
    logic [c_DATA_W-1:0]   a;
    logic [c_DATA_W-1:0]   b;
    logic                  use_acc;
    logic [c_TAG_W-1:0]    tag;
  } CmdT;

  function automatic logic is_legal(input Op op);
    return (4'(op) <= 4'(OP_SRA));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Alu : 8-bit combinational datapath; shifts use the full 8-bit b amount.
// Rev 1.1
// ============================================================================
module Alu
  import alu_pkg::*;
(
  input  Op          i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_y
);

  always_comb begin
    o_y = 8'd0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_SLT:  o_y = {7'd0, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: o_y = {7'd0, (i_a < i_b)};
      OP_SLL:  o_y = i_a << i_b;
      OP_SRL:  o_y = i_a >> i_b;
      OP_SRA:  o_y = $unsigned($signed(i_a) >>> i_b);
      default: o_y = 8'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// alu_cmd_fifo : in-order CmdT FIFO, wrap-bit pointers for full/empty.
// Rev 1.1
// ============================================================================
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  CmdT  i_data,
  input  logic i_pop,
  output CmdT  o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  CmdT              r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
// alu_ctrl : command FIFO -> Alu -> response register, with accumulator.
// Optional error flag on rsp_err when ALU_CTRL_ERR_EN is defined. Rev 1.1
// ============================================================================
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  Op          cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  input  logic [1:0] cmd_tag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_x,
  output logic [1:0] rsp_tag,
`ifdef ALU_CTRL_ERR_EN
  output logic       rsp_err,
`endif
  output logic [7:0] acc,
  output logic       busy
);

  CmdT        w_cmd_in;
  CmdT        w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_issue;
  logic       w_legal;
  logic [7:0] w_op_a;
  logic [7:0] w_alu_y;

  logic       r_rsp_valid;
  logic [7:0] r_rsp_x;
  logic [1:0] r_rsp_tag;
  logic [7:0] r_acc;

  assign w_cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc, tag: cmd_tag};
  assign w_push   = cmd_valid && !w_full;
  assign w_issue  = !w_empty && (!r_rsp_valid || rsp_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Accumulator bypass: r_acc already holds the previous issue's result.
  assign w_op_a  = w_head.use_acc ? r_acc : w_head.a;
  assign w_legal = is_legal(w_head.op);

  Alu u_alu (
    .i_op (w_head.op),
    .i_a  (w_op_a),
    .i_b  (w_head.b),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_x     <= 8'd0;
      r_rsp_tag   <= 2'd0;
      r_acc       <= 8'd0;
    end else if (w_issue) begin
      r_rsp_valid <= 1'b1;
      r_rsp_x     <= w_legal ? w_alu_y : 8'd0;
      r_rsp_tag   <= w_head.tag;
      if (w_legal) r_acc <= w_alu_y;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_CTRL_ERR_EN
  logic r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_rsp_err <= 1'b0;
    else if (w_issue) r_rsp_err <= !w_legal;
  end

  assign rsp_err = r_rsp_err;
`endif

  assign cmd_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_x     = r_rsp_x;
  assign rsp_tag   = r_rsp_tag;
  assign acc       = r_acc;
  assign busy      = !w_empty || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_ctrl : vector table, directed corner sequences, randomized model run.
// Rev 1.1
// ============================================================================
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  Op          cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic [1:0] cmd_tag;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_x;
  logic [1:0] rsp_tag;
  logic       rsp_err_w;
  logic [7:0] acc;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .cmd_tag     (cmd_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_x       (rsp_x),
    .rsp_tag     (rsp_tag),
`ifdef ALU_CTRL_ERR_EN
    .rsp_err     (rsp_err_w),
`endif
    .acc         (acc),
    .busy        (busy)
  );

`ifndef ALU_CTRL_ERR_EN
  assign rsp_err_w = 1'b0;
`endif

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic [1:0] tag;
    logic [7:0] ex;
    logic       ee;
    logic [7:0] eacc;
  } vec_t;

  typedef struct {
    logic [7:0] x;
    logic [1:0] tag;
    logic       err;
  } exp_t;

  vec_t tbl [16];
  exp_t q [$];
  logic [7:0] m_acc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Reference ALU from the operation definitions, using integer arithmetic.
  function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
    int r;
    int sa;
    int sb;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = (a < b) ? 1 : 0;
      7: r = (b > 7) ? 0 : a * (2 ** b);
      8: r = (b > 7) ? 0 : a / (2 ** b);
      9: r = sa >>> ((b > 7) ? 7 : b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ua, input logic [1:0] tag);
    cmd_valid   = 1'b1;
    cmd_op      = Op'(op);
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    cmd_tag     = tag;
  endtask

  task automatic run_vec(input int i);
    drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].use_acc, tbl[i].tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_latency_early", i), rsp_valid, 0);
    @(negedge clk);
    chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, 1);
    chk($sformatf("vec%0d_rsp_x", i), rsp_x, tbl[i].ex);
    chk($sformatf("vec%0d_rsp_tag", i), rsp_tag, tbl[i].tag);
    chk($sformatf("vec%0d_acc", i), acc, tbl[i].eacc);
`ifdef ALU_CTRL_ERR_EN
    chk($sformatf("vec%0d_rsp_err", i), rsp_err_w, tbl[i].ee);
`endif
    @(posedge clk); #1;
  endtask

  // One cycle of model bookkeeping at the negedge, before the next edge acts.
  task automatic model_sample(input string ph);
    exp_t e;
    chk({ph, "_busy"}, busy, (q.size() != 0) ? 1 : 0);
    if (q.size() < DEPTH)      chk({ph, "_cmd_ready_free"}, cmd_ready, 1);
    if (q.size() == DEPTH + 1) chk({ph, "_cmd_ready_full"}, cmd_ready, 0);
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk({ph, "_unexpected_rsp"}, 1, 0);
      end else begin
        e = q.pop_front();
        chk({ph, "_rsp_x"}, rsp_x, e.x);
        chk({ph, "_rsp_tag"}, rsp_tag, e.tag);
`ifdef ALU_CTRL_ERR_EN
        chk({ph, "_rsp_err"}, rsp_err_w, e.err);
`endif
      end
    end
    if (cmd_valid && cmd_ready) begin
      logic [7:0] oa;
      oa    = cmd_use_acc ? m_acc : cmd_a;
      e.tag = cmd_tag;
      e.err = (int'(cmd_op) > 9);
      e.x   = e.err ? 8'd0 : ref_alu(int'(cmd_op), int'(oa), int'(cmd_b));
      if (!e.err) m_acc = e.x;
      q.push_back(e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic acc6;

    tbl[0]  = '{4'd0, 8'h05, 8'h03, 1'b0, 2'd1, 8'h08, 1'b0, 8'h08};
    tbl[1]  = '{4'd0, 8'h77, 8'h02, 1'b1, 2'd2, 8'h0A, 1'b0, 8'h0A};
    tbl[2]  = '{4'd5, 8'hFF, 8'h01, 1'b0, 2'd2, 8'h01, 1'b0, 8'h01};
    tbl[3]  = '{4'd6, 8'hFF, 8'h01, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00};
    tbl[4]  = '{4'd8, 8'h80, 8'h09, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00};
    tbl[5]  = '{4'd1, 8'h03, 8'h05, 1'b0, 2'd1, 8'hFE, 1'b0, 8'hFE};
    tbl[6]  = '{4'd9, 8'h80, 8'h01, 1'b0, 2'd3, 8'hC0, 1'b0, 8'hC0};
    tbl[7]  = '{4'd7, 8'h81, 8'h01, 1'b0, 2'd0, 8'h02, 1'b0, 8'h02};
    tbl[8]  = '{4'd4, 8'hF0, 8'h3C, 1'b0, 2'd1, 8'hCC, 1'b0, 8'hCC};
    tbl[9]  = '{4'd2, 8'hF0, 8'h3C, 1'b0, 2'd2, 8'h30, 1'b0, 8'h30};
    tbl[10] = '{4'd0, 8'h20, 8'h02, 1'b0, 2'd3, 8'h22, 1'b0, 8'h22};
    tbl[11] = '{4'hF, 8'h00, 8'h05, 1'b1, 2'd2, 8'h00, 1'b1, 8'h22};
    tbl[12] = '{4'hA, 8'h01, 8'h01, 1'b0, 2'd0, 8'h00, 1'b1, 8'h22};
    tbl[13] = '{4'd3, 8'h00, 8'h41, 1'b1, 2'd1, 8'h63, 1'b0, 8'h63};
    tbl[14] = '{4'd9, 8'h40, 8'h14, 1'b0, 2'd2, 8'h00, 1'b0, 8'h00};
    tbl[15] = '{4'd9, 8'h90, 8'hC8, 1'b0, 2'd3, 8'hFF, 1'b0, 8'hFF};

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = OP_ADD; cmd_a = 8'd0; cmd_b = 8'd0; cmd_use_acc = 1'b0; cmd_tag = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_x", rsp_x, 0);
    chk("reset_rsp_tag", rsp_tag, 0);
    chk("reset_acc", acc, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
`ifdef ALU_CTRL_ERR_EN
    chk("reset_rsp_err", rsp_err_w, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Back-to-back accumulator chain: 10, 7, 14 on consecutive cycles.
    rsp_ready = 1'b1;
    drive(4'd0, 8'd10, 8'd0, 1'b0, 2'd1);
    @(posedge clk); #1;
    drive(4'd1, 8'h00, 8'd3, 1'b1, 2'd2);
    @(posedge clk); #1;
    drive(4'd7, 8'h00, 8'd1, 1'b1, 2'd3);
    @(negedge clk);
    chk("chain0_valid", rsp_valid, 1);
    chk("chain0_x", rsp_x, 10);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("chain1_valid", rsp_valid, 1);
    chk("chain1_x", rsp_x, 7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("chain2_valid", rsp_valid, 1);
    chk("chain2_x", rsp_x, 14);
    chk("chain2_tag", rsp_tag, 3);
    chk("chain_acc", acc, 14);
    @(posedge clk); #1;

    // Capacity: DEPTH+1 accepted while stalled, the sixth waits.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 8'(8'h10 + i), 8'(i), 1'b0, 2'(i % 4));
      @(negedge clk);
      chk($sformatf("cap_ready%0d", i), cmd_ready, 1);
      @(posedge clk); #1;
    end
    drive(4'd0, 8'h15, 8'd5, 1'b0, 2'd1);
    @(negedge clk);
    chk("cap_full_ready", cmd_ready, 0);
    chk("cap_rsp_held_x", rsp_x, 8'h10);
    @(posedge clk); #1;
    chk("cap_rsp_stable_x", rsp_x, 8'h10);
    rsp_ready = 1'b1;
    k = 0;
    acc6 = 1'b0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk($sformatf("cap_drain%0d_x", k), rsp_x, 8'h10 + 2 * k);
        chk($sformatf("cap_drain%0d_tag", k), rsp_tag, k % 4);
        k++;
      end
      if (cmd_valid && cmd_ready) acc6 = 1'b1;
      @(posedge clk); #1;
      if (acc6) cmd_valid = 1'b0;
    end
    chk("cap_drain_count", k, 6);
    chk("cap_sixth_accepted", acc6, 1);
    chk("cap_acc", acc, 8'h1A);

    // Reset with a held response and three queued commands.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 8'h40, 8'(i), 1'b0, 2'd3);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_valid", rsp_valid, 1);
    chk("midrst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_x", rsp_x, 0);
    chk("midrst_rsp_tag", rsp_tag, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
`ifdef ALU_CTRL_ERR_EN
    chk("midrst_rsp_err", rsp_err_w, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("postrst_no_stale", rsp_valid, 0);
      chk("postrst_busy", busy, 0);
    end
    @(posedge clk); #1;

    // Randomized traffic against the queue/accumulator model.
    m_acc = 8'd0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) rop = 4'($urandom_range(10, 15));
      drive(rop, 8'($urandom), 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom),
            1'($urandom), 2'($urandom));
      cmd_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      model_sample("rand");
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      model_sample("drain");
      @(posedge clk); #1;
    end
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_final_acc", acc, m_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
